// File: rtl/spi_wb_sequencer_if.sv
// Request/response handshake and Wishbone master bus of spi_wb_sequencer.
// master = sequencer side, slave = requester plus simple_spi side.
interface spi_wb_sequencer_if #(
    parameter int SS_WIDTH = 8
);
    localparam int SS_IW = (SS_WIDTH > 1) ? $clog2(SS_WIDTH) : 1;

    logic             req_valid;
    logic             req_ready;
    logic [SS_IW-1:0] req_ss;
    logic [7:0]       req_data;
    logic [1:0]       req_mode;
    logic [3:0]       req_div;
    logic             req_hold;
    logic             rsp_valid;
    logic [7:0]       rsp_data;
    logic             rsp_err;
    logic             cyc_o;
    logic             stb_o;
    logic [2:0]       adr_o;
    logic             we_o;
    logic [7:0]       dat_o;
    logic [7:0]       dat_i;
    logic             ack_i;

    modport master (
        input  req_valid, req_ss, req_data, req_mode, req_div, req_hold, dat_i, ack_i,
        output req_ready, rsp_valid, rsp_data, rsp_err, cyc_o, stb_o, adr_o, we_o, dat_o
    );

    modport slave (
        output req_valid, req_ss, req_data, req_mode, req_div, req_hold, dat_i, ack_i,
        input  req_ready, rsp_valid, rsp_data, rsp_err, cyc_o, stb_o, adr_o, we_o, dat_o
    );
endinterface

// File: rtl/spi_wb_sequencer.sv
// Wishbone master that drives one simple_spi core in polled mode for single-byte
// transfers, caching SPCR/SPER/SS so that unchanged configuration is not rewritten.
module spi_wb_sequencer #(
    parameter int SS_WIDTH = 8,
    parameter int POLL_MAX = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    spi_wb_sequencer_if.master  bus
);
    localparam int SS_IW = (SS_WIDTH > 1) ? $clog2(SS_WIDTH) : 1;
    localparam int PW    = $clog2(POLL_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_W_SPCR, S_W_SPER, S_W_SS, S_W_SPDR, S_R_SPSR, S_R_SPDR,
        S_W_SPSR, S_W_SSOFF, S_A_SPCR, S_A_SS, S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic             stb_q, stb_d, we_q, we_d;
    logic [2:0]       adr_q, adr_d;
    logic [7:0]       dat_q, dat_d;
    logic             req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [7:0]       rsp_data_q, rsp_data_d, rx_q, rx_d, data_q, data_d;
    logic [SS_IW-1:0] ss_q, ss_d, ss_c_q, ss_c_d;
    logic [1:0]       mode_q, mode_d, mode_c_q, mode_c_d;
    logic [3:0]       div_q, div_d, div_c_q, div_c_d;
    logic             hold_q, hold_d, err_q, err_d;
    logic             cache_valid_q, cache_valid_d, ss_active_q, ss_active_d;
    logic [PW-1:0]    poll_q, poll_d;

    logic             accept_s, done_s, cfg_hit_s, ss_hit_req_s, ss_hit_lat_s, poll_last_s;
    logic             acc_s, acc_we_s;
    logic [2:0]       acc_adr_s;
    logic [7:0]       acc_dat_s;

    assign accept_s     = bus.req_valid && req_ready_q;
    assign done_s       = stb_q && bus.ack_i;
    assign cfg_hit_s    = cache_valid_q && (bus.req_mode == mode_c_q) && (bus.req_div == div_c_q);
    assign ss_hit_req_s = ss_active_q && (bus.req_ss == ss_c_q);
    assign ss_hit_lat_s = ss_active_q && (ss_q == ss_c_q);
    assign poll_last_s  = (poll_q == PW'(POLL_MAX - 1));

    assign bus.cyc_o     = stb_q;
    assign bus.stb_o     = stb_q;
    assign bus.adr_o     = adr_q;
    assign bus.we_o      = we_q;
    assign bus.dat_o     = dat_q;
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: every access state advances only on its acknowledge
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!accept_s)          state_d = S_IDLE;
                else if (!cfg_hit_s)    state_d = S_W_SPCR;
                else if (!ss_hit_req_s) state_d = S_W_SS;
                else                    state_d = S_W_SPDR;
            end
            S_W_SPCR:  state_d = done_s ? S_W_SPER : state_q;
            S_W_SPER:  state_d = done_s ? (ss_hit_lat_s ? S_W_SPDR : S_W_SS) : state_q;
            S_W_SS:    state_d = done_s ? S_W_SPDR : state_q;
            S_W_SPDR:  state_d = done_s ? S_R_SPSR : state_q;
            S_R_SPSR: begin
                if (!done_s)            state_d = state_q;
                else if (bus.dat_i[7])  state_d = S_R_SPDR;
                else if (poll_last_s)   state_d = S_A_SPCR;
                else                    state_d = S_R_SPSR;
            end
            S_R_SPDR:  state_d = done_s ? S_W_SPSR : state_q;
            S_W_SPSR:  state_d = done_s ? (hold_q ? S_RESP : S_W_SSOFF) : state_q;
            S_W_SSOFF: state_d = done_s ? S_RESP : state_q;
            S_A_SPCR:  state_d = done_s ? S_A_SS : state_q;
            S_A_SS:    state_d = done_s ? S_RESP : state_q;
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        acc_s = 1'b1; acc_we_s = 1'b1; acc_adr_s = 3'd0; acc_dat_s = 8'h00;
        stb_d = stb_q; we_d = we_q; adr_d = adr_q; dat_d = dat_q;
        ss_d = ss_q; data_d = data_q; mode_d = mode_q; div_d = div_q; hold_d = hold_q;
        ss_c_d = ss_c_q; mode_c_d = mode_c_q; div_c_d = div_c_q;
        cache_valid_d = cache_valid_q; ss_active_d = ss_active_q;
        poll_d = poll_q; err_d = err_q; rx_d = rx_q;
        rsp_data_d = rsp_data_q; rsp_err_d = rsp_err_q;
        case (state_q)
            S_W_SPCR:  acc_dat_s = {1'b0, 1'b1, 1'b0, 1'b1, mode_q, div_q[1:0]};
            S_W_SPER: begin acc_adr_s = 3'd3; acc_dat_s = {6'b000000, div_q[3:2]}; end
            S_W_SS:   begin acc_adr_s = 3'd4; acc_dat_s = 8'd1 << ss_q; end
            S_W_SPDR: begin acc_adr_s = 3'd2; acc_dat_s = data_q; end
            S_R_SPSR: begin acc_adr_s = 3'd1; acc_we_s = 1'b0; end
            S_R_SPDR: begin acc_adr_s = 3'd2; acc_we_s = 1'b0; end
            S_W_SPSR: begin acc_adr_s = 3'd1; acc_dat_s = 8'h80; end
            S_W_SSOFF: acc_adr_s = 3'd4;
            S_A_SPCR:  acc_dat_s = 8'h10;
            S_A_SS:    acc_adr_s = 3'd4;
            default: begin acc_s = 1'b0; acc_we_s = 1'b0; end
        endcase

        // A strobe that has just been acked drops for one cycle before the next access
        if (stb_q) begin
            stb_d = !bus.ack_i;
        end else if (acc_s) begin
            stb_d = 1'b1; adr_d = acc_adr_s; we_d = acc_we_s; dat_d = acc_dat_s;
        end else begin
            stb_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    ss_d = bus.req_ss; data_d = bus.req_data; mode_d = bus.req_mode;
                    div_d = bus.req_div; hold_d = bus.req_hold;
                    poll_d = '0; err_d = 1'b0;
                end else begin
                    poll_d = poll_q;
                end
            end
            S_W_SPER: begin
                if (done_s) begin
                    cache_valid_d = 1'b1; mode_c_d = mode_q; div_c_d = div_q;
                end else begin
                    cache_valid_d = cache_valid_q;
                end
            end
            S_W_SS:   ss_c_d = done_s ? ss_q : ss_c_q;
            S_R_SPSR: begin
                if (done_s) begin
                    poll_d = poll_q + PW'(1);
                    if (!bus.dat_i[7] && poll_last_s) begin
                        cache_valid_d = 1'b0; ss_active_d = 1'b0; err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                end else begin
                    poll_d = poll_q;
                end
            end
            S_R_SPDR:  rx_d = done_s ? bus.dat_i : rx_q;
            S_W_SPSR:  ss_active_d = (done_s && hold_q) ? 1'b1 : ss_active_q;
            S_W_SSOFF: ss_active_d = done_s ? 1'b0 : ss_active_q;
            default:   err_d = err_q;
        endcase

        rsp_valid_d = (state_d == S_RESP);
        req_ready_d = (state_d == S_IDLE);
        if (state_d == S_RESP) begin
            rsp_data_d = err_q ? 8'h00 : rx_q;
            rsp_err_d  = err_q;
        end else begin
            rsp_data_d = rsp_data_q;
        end
    end

    // Datapath and bus output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stb_q <= 1'b0; we_q <= 1'b0; adr_q <= 3'd0; dat_q <= 8'h00;
            req_ready_q <= 1'b1; rsp_valid_q <= 1'b0; rsp_data_q <= 8'h00; rsp_err_q <= 1'b0;
            ss_q <= '0; data_q <= 8'h00; mode_q <= 2'd0; div_q <= 4'd0; hold_q <= 1'b0;
            ss_c_q <= '0; mode_c_q <= 2'd0; div_c_q <= 4'd0;
            cache_valid_q <= 1'b0; ss_active_q <= 1'b0;
            poll_q <= '0; err_q <= 1'b0; rx_q <= 8'h00;
        end else begin
            stb_q <= stb_d; we_q <= we_d; adr_q <= adr_d; dat_q <= dat_d;
            req_ready_q <= req_ready_d; rsp_valid_q <= rsp_valid_d;
            rsp_data_q <= rsp_data_d; rsp_err_q <= rsp_err_d;
            ss_q <= ss_d; data_q <= data_d; mode_q <= mode_d; div_q <= div_d; hold_q <= hold_d;
            ss_c_q <= ss_c_d; mode_c_q <= mode_c_d; div_c_q <= div_c_d;
            cache_valid_q <= cache_valid_d; ss_active_q <= ss_active_d;
            poll_q <= poll_d; err_q <= err_d; rx_q <= rx_d;
        end
    end
endmodule

// File: tb/tb_spi_wb_sequencer.sv
// Bench for spi_wb_sequencer against a behavioural simple_spi register model with
// MISO looped back to MOSI; expected WB writes and responses go through queues.
module tb_spi_wb_sequencer;
    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    spi_wb_sequencer_if #(.SS_WIDTH(8)) bus ();
    spi_wb_sequencer #(.SS_WIDTH(8), .POLL_MAX(16)) dut (.clk_i(clk), .rst_i(rst_i), .bus(bus));

    typedef struct {
        logic [2:0] ss; logic [7:0] data; logic [1:0] mode; logic [3:0] div;
        logic hold; logic stub; logic cfg; logic ssw; logic off; int polls;
    } vec_t;
    typedef struct packed { logic [2:0] adr; logic [7:0] dat; } wr_t;
    typedef struct packed { logic err; logic [7:0] dat; } rsp_t;

    vec_t vt[10];
    wr_t  wq[$];
    rsp_t rq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic stub = 1'b0;

    // simple_spi model: registered ack, SPIF 20 cycles after an SPDR write unless stubbed
    logic [7:0] spcr_m, ss_m, rx_m, seen_ss;
    logic [1:0] seen_mode;
    logic       spif_m;
    int         busy_m;
    always @(posedge clk) begin
        if (rst_i) begin
            bus.ack_i <= 1'b0; bus.dat_i <= 8'h00; spcr_m <= 8'h00; ss_m <= 8'h00;
            rx_m <= 8'h00; spif_m <= 1'b0; busy_m <= 0; seen_ss <= 8'h00; seen_mode <= 2'd0;
        end else begin
            bus.ack_i <= 1'b0;
            if (busy_m != 0) begin
                busy_m <= busy_m - 1;
                if (busy_m == 1) spif_m <= 1'b1;
            end
            if (bus.cyc_o && bus.stb_o && !bus.ack_i) begin
                bus.ack_i <= 1'b1;
                if (bus.we_o) begin
                    case (bus.adr_o)
                        3'd0: spcr_m <= bus.dat_o;
                        3'd4: ss_m <= bus.dat_o;
                        3'd2: begin
                            rx_m <= bus.dat_o; seen_mode <= spcr_m[3:2]; seen_ss <= ss_m;
                            if (!stub) busy_m <= 20;
                        end
                        3'd1: if (bus.dat_o[7]) spif_m <= 1'b0;
                        default: ;
                    endcase
                end else begin
                    case (bus.adr_o)
                        3'd1: bus.dat_i <= {spif_m, 7'b0000000};
                        3'd2: bus.dat_i <= rx_m;
                        default: bus.dat_i <= 8'h00;
                    endcase
                end
            end
        end
    end

    function automatic vec_t mk(input logic [2:0] ss, input logic [7:0] data, input logic [1:0] mode,
                                input logic [3:0] div, input logic hold, input logic stb,
                                input logic cfg, input logic ssw, input logic off, input int polls);
        vec_t v;
        v.ss = ss; v.data = data; v.mode = mode; v.div = div; v.hold = hold; v.stub = stb;
        v.cfg = cfg; v.ssw = ssw; v.off = off; v.polls = polls;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive_req(input vec_t v);
        bus.req_ss = v.ss; bus.req_data = v.data; bus.req_mode = v.mode;
        bus.req_div = v.div; bus.req_hold = v.hold; bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        wr_t  w;
        rsp_t r;
        logic [7:0] one_hot;
        int polls = 0;
        bit got = 0;
        one_hot = 8'd1 << v.ss;
        if (v.cfg) begin
            wq.push_back({3'd0, {1'b0, 1'b1, 1'b0, 1'b1, v.mode, v.div[1:0]}});
            wq.push_back({3'd3, {6'b000000, v.div[3:2]}});
        end
        if (v.ssw) wq.push_back({3'd4, one_hot});
        wq.push_back({3'd2, v.data});
        if (v.stub) begin
            wq.push_back({3'd0, 8'h10});
            wq.push_back({3'd4, 8'h00});
            rq.push_back({1'b1, 8'h00});
        end else begin
            wq.push_back({3'd1, 8'h80});
            if (v.off) wq.push_back({3'd4, 8'h00});
            rq.push_back({1'b0, v.data});
        end
        stub = v.stub;
        check("ready_idle", idx, 32'(bus.req_ready), 32'd1);
        drive_req(v);
        check("ready_drop", idx, 32'(bus.req_ready), 32'd0);
        for (int c = 0; c < 3000 && !got; c++) begin
            if (bus.cyc_o && bus.stb_o && bus.ack_i) begin
                if (bus.we_o) begin
                    if (wq.size() == 0) begin
                        check("extra_write", idx, {21'd0, bus.adr_o, bus.dat_o}, 32'hFFFF);
                    end else begin
                        w = wq.pop_front();
                        check("wr_adr", idx, 32'(bus.adr_o), 32'(w.adr));
                        check("wr_dat", idx, 32'(bus.dat_o), 32'(w.dat));
                    end
                end else if (bus.adr_o == 3'd1) begin
                    polls++;
                end
            end
            if (bus.rsp_valid) begin
                got = 1;
                r = rq.pop_front();
                check("rsp_data", idx, 32'(bus.rsp_data), 32'(r.dat));
                check("rsp_err", idx, 32'(bus.rsp_err), 32'(r.err));
            end
            @(negedge clk);
        end
        check("rsp_seen", idx, 32'(got), 32'd1);
        check("writes_left", idx, 32'(wq.size()), 32'd0);
        wq.delete();
        rq.delete();
        if (v.polls != 0) check("spsr_reads", idx, 32'(polls), 32'(v.polls));
        check("rsp_one_cycle", idx, 32'(bus.rsp_valid), 32'd0);
        check("ready_back", idx, 32'(bus.req_ready), 32'd1);
        if (!v.stub) begin
            check("spi_mode", idx, 32'(seen_mode), 32'(v.mode));
            check("ss_line", idx, 32'(~seen_ss), 32'(~one_hot));
        end
    endtask

    task automatic reset_mid_poll(input vec_t v, input int idx);
        bit seen = 0;
        int rsp_cnt = 0;
        stub = 1'b0;
        drive_req(v);
        for (int c = 0; c < 500 && !seen; c++) begin
            if (bus.cyc_o && bus.stb_o && !bus.we_o && bus.adr_o == 3'd1) seen = 1;
            else @(negedge clk);
        end
        check("poll_reached", idx, 32'(seen), 32'd1);
        rst_i = 1'b1;
        @(negedge clk);
        check("rst_cyc", idx, 32'(bus.cyc_o), 32'd0);
        check("rst_stb", idx, 32'(bus.stb_o), 32'd0);
        check("rst_ready", idx, 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst_i = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (bus.rsp_valid) rsp_cnt++;
            @(negedge clk);
        end
        check("rst_no_rsp", idx, 32'(rsp_cnt), 32'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        bus.req_valid = 1'b0; bus.req_ss = 3'd0; bus.req_data = 8'h00;
        bus.req_mode = 2'd0; bus.req_div = 4'd0; bus.req_hold = 1'b0;
        //           ss    data   mode  div     hold  stub  cfg   ssw   off  polls
        vt[0] = mk(3'd2, 8'hA5, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        vt[1] = mk(3'd2, 8'h5A, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        vt[2] = mk(3'd5, 8'h3C, 2'd0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        vt[3] = mk(3'd5, 8'hC3, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        vt[4] = mk(3'd1, 8'h96, 2'd3, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        vt[5] = mk(3'd1, 8'h11, 2'd3, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16);
        vt[6] = mk(3'd1, 8'h22, 2'd3, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        vt[7] = mk(3'd0, 8'hFF, 2'd1, 4'b1001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        vt[8] = mk(3'd7, 8'h00, 2'd1, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        vt[9] = mk(3'd3, 8'h77, 2'd1, 4'b1001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        repeat (7) @(negedge clk);
        check("reset_ready", -1, 32'(bus.req_ready), 32'd1);
        check("reset_cyc", -1, 32'(bus.cyc_o), 32'd0);
        check("reset_rsp", -1, 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_data", -1, 32'(bus.rsp_data), 32'd0);
        rst_i = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 9; i++) run_vec(vt[i], i);
        // Cache for mode 1/div 9 is valid here; reset must force full reconfiguration
        reset_mid_poll(vt[9], 9);
        run_vec(vt[9], 9);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_wb_sequencer.md
Name: spi_wb_sequencer

Overview:
- Wishbone master that sequences one simple_spi core (8-bit WB slave) on behalf of a single byte-transfer requester.
- Accepts a request (slave index, TX byte, SPI mode, clock divider, hold flag) and performs the register writes and SPSR polling in polled mode (SPIE=0).
- Returns the received byte.
- Caches the last SPCR/SPER/SS values and skips redundant writes.

Parameters:
- SS_WIDTH, 8, number of slave-select lines in the attached simple_spi.
- POLL_MAX, 1024, maximum SPSR reads per transfer before abort.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active high
- req_valid  in  1  transfer request
- req_ready  out  1  sequencer can accept request
- req_ss  in  $clog2(SS_WIDTH)  slave index
- req_data  in  8  TX byte
- req_mode  in  2  {CPOL,CPHA}
- req_div  in  4  {ESPR[1:0],SPR[1:0]}
- req_hold  in  1  keep SS asserted after transfer
- rsp_valid  out  1  one-cycle response strobe
- rsp_data  out  8  RX byte
- rsp_err  out  1  poll timeout (valid with rsp_valid)
- cyc_o  out  1  WB cycle
- stb_o  out  1  WB strobe
- adr_o  out  3  WB address
- we_o  out  1  WB write enable
- dat_o  out  8  WB write data
- dat_i  in  8  WB read data
- ack_i  in  1  WB acknowledge

Behaviour:
- Reset: all outputs 0 except req_ready=1. Cache invalid, ss_active=0. Reset mid-operation aborts immediately; no response is issued.
- Request handshake:
  - Accept on req_valid&&req_ready.
  - All request fields are latched; req_ready drops the next cycle.
  - req_ready returns high the cycle after rsp_valid.
- WB access (one per state):
  - cyc_o/stb_o rise with adr/we/dat stable and are held until ack_i.
  - On the ack cycle, read data is captured.
  - cyc/stb are 0 for exactly one cycle before the next access.
  - Against simple_spi, each access takes 2 cycles plus 1 gap.
- Register values:
  - SPCR = {1'b0,1'b1,1'b0,1'b1,CPOL,CPHA,SPR}.
  - SPER = {2'b00,4'b0,ESPR}.
  - SS = 1<<req_ss.
- State sequence after accept:
  - W_SPCR and W_SPER (adr 0, 3): only if the cache is invalid or mode/div differ from the cache.
  - W_SS (adr 4): only if !ss_active or req_ss differs from the cached index.
  - W_SPDR (adr 2, req_data).
  - R_SPSR (adr 1): repeat until dat_i[7]=1. The poll counter increments per read. When the count reaches POLL_MAX without SPIF, go to ABORT.
  - R_SPDR (adr 2): capture rsp_data.
  - W_SPSR (adr 1, 8'h80): clears SPIF.
  - If !req_hold, W_SSOFF (adr 4, 8'h00) and ss_active=0; else ss_active=1.
  - RESP: rsp_valid=1 for one cycle, rsp_err=0.
- ABORT:
  - Writes SPCR with SPE=0 (8'h10), then 8'h00 to SS.
  - Invalidates the cache; ss_active=0.
  - RESP with rsp_err=1, rsp_data=8'h00.
- Cache update: cache is valid after W_SPER completes.
- ack_i outside an active strobe is ignored.
- rsp_data holds its value until the next response.

Test Plan:
- Reset with rst_i=1 for 7 cycles, then req_valid with ss=2, data=8'hA5, mode=0, div=0, hold=0:
  - WB writes are, in order, adr0=8'h50, adr3=8'h00, adr4=8'h04, adr2=8'hA5.
  - Then SPSR polls, then adr1=8'h80 and adr4=8'h00.
  - rsp_valid fires once; rsp_data equals the MISO-looped byte.
- Second request with identical mode/div and ss=2, hold=0 -> no SPCR/SPER writes. The first access is W_SS adr4=8'h04.
- Request with hold=1 (ss=5, data=8'h3C) followed by a request with ss=5, hold=0:
  - No SS writes between the two bytes.
  - ss_o stays 8'hDF throughout both bytes.
  - A single adr4=8'h00 write occurs at the end.
- Change mode to 3 and div to 4'b0110 -> SPCR=8'h5E, SPER=8'h01 are rewritten. The SPI monitor sees CPOL=1/CPHA=1 at the expected sck rate.
- Bench never returns SPIF (stubbed ack slave, dat_i=0) with POLL_MAX=16:
  - Exactly 16 SPSR reads occur.
  - Then adr0=8'h10 and adr4=8'h00 are written.
  - rsp_err=1 and rsp_data=8'h00.
  - The next request rewrites SPCR.
- Assert rst_i during R_SPSR polling:
  - cyc_o/stb_o are 0 and req_ready=1 the cycle after the reset edge.
  - No rsp_valid is issued.
  - The next request performs the full configuration sequence.
